// File: rtl/mem_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: funct3 encodings, access sizes,
// FSM states and the pipeline interconnection record.
package mem_lsu_pkg;

    localparam int LSU_XLEN   = 64;
    localparam int LSU_STRB_W = LSU_XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic                is_valid;
        logic [4:0]          rd;
        logic                rf_we;
        logic                mem_rd;
        logic                mem_wr;
        logic [2:0]          funct3;
        logic [LSU_XLEN-1:0] mem_addr;
        logic [LSU_XLEN-1:0] mem_data;
        logic [LSU_XLEN-1:0] rf_wr_data;
    } interconnection_struct;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Single-outstanding request/grant/response data-memory port.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic                    dmem_req;
    logic                    dmem_we;
    logic [LSU_XLEN-1:0]     dmem_addr;
    logic [LSU_STRB_W-1:0]   dmem_be;
    logic [LSU_XLEN-1:0]     dmem_wdata;
    logic                    dmem_gnt;
    logic                    dmem_rvalid;
    logic [LSU_XLEN-1:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store byte-enables/data placement and load extract/extend.
module mem_lsu_align import mem_lsu_pkg::*; #(
    parameter int XLEN   = LSU_XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              zext,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [STRB_W-1:0] be_mask;
    logic [XLEN-1:0]   data_mask;
    logic [XLEN-1:0]   sh;
    logic [5:0]        bit_off;

    assign bit_off = {off, 3'b000};

    always_comb begin
        be_mask   = '0;
        data_mask = '0;
        case (size)
            SZ_B: begin
                be_mask   = STRB_W'(8'h01);
                data_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            SZ_H: begin
                be_mask   = STRB_W'(8'h03);
                data_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            SZ_W: begin
                be_mask   = STRB_W'(8'h0F);
                data_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            default: begin
                be_mask   = '1;
                data_mask = '1;
            end
        endcase
    end

    // Bytes outside the enabled lanes are forced to zero rather than left as garbage.
    assign be    = be_mask << off;
    assign wdata = (st_data & data_mask) << bit_off;
    assign sh    = rdata >> bit_off;

    always_comb begin
        ld_data = sh;
        case (size)
            SZ_B:    ld_data = {{(XLEN-8){~zext & sh[7]}}, sh[7:0]};
            SZ_H:    ld_data = {{(XLEN-16){~zext & sh[15]}}, sh[15:0]};
            SZ_W:    ld_data = {{(XLEN-32){~zext & sh[31]}}, sh[31:0]};
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: captures one aligned access, runs it over the
// request/grant/response port while stalling upstream, then hands the result to WB.
module mem_lsu import mem_lsu_pkg::*; #(
    parameter int XLEN   = LSU_XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  interconnection_struct i_struct,
    output interconnection_struct o_struct,
    output logic                 o_stall,
    output logic                 o_misalign,
    mem_lsu_if.master            bus
);

    lsu_state_t            state_q, state_d;
    interconnection_struct cap_q, cap_d;
    interconnection_struct o_struct_q, o_struct_d;
    logic                  o_misalign_q, o_misalign_d;
    logic                  mem_op;
    logic                  req;
    logic [STRB_W-1:0]     al_be;
    logic [XLEN-1:0]       al_wdata;
    logic [XLEN-1:0]       al_ld;

    mem_lsu_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
        .off     (cap_q.mem_addr[2:0]),
        .size    (cap_q.funct3[1:0]),
        .zext    (cap_q.funct3[2]),
        .st_data (cap_q.mem_data),
        .rdata   (bus.dmem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    assign mem_op = i_struct.is_valid & (i_struct.mem_rd | i_struct.mem_wr);

    always_comb begin
        state_d             = state_q;
        cap_d               = cap_q;
        o_struct_d          = o_struct_q;
        o_struct_d.is_valid = 1'b0;
        o_misalign_d        = 1'b0;
        o_stall             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && is_misaligned(i_struct.mem_addr[2:0], i_struct.funct3[1:0])) begin
                    o_struct_d          = i_struct;
                    o_struct_d.is_valid = 1'b0;
                    o_misalign_d        = 1'b1;
                end else if (mem_op) begin
                    cap_d        = i_struct;
                    // rd+wr together behaves as a load
                    cap_d.mem_wr = i_struct.mem_wr & ~i_struct.mem_rd;
                    state_d      = ST_REQ;
                    o_stall      = 1'b1;
                end else begin
                    o_struct_d = i_struct;
                end
            end
            ST_REQ: begin
                o_stall = 1'b1;
                if (bus.dmem_gnt) begin
                    if (cap_q.mem_wr) begin
                        state_d    = ST_IDLE;
                        o_struct_d = cap_q;
                        o_stall    = 1'b0;
                    end else if (bus.dmem_rvalid) begin
                        state_d               = ST_IDLE;
                        o_struct_d            = cap_q;
                        o_struct_d.rf_wr_data = al_ld;
                        o_stall               = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                o_stall = 1'b1;
                if (bus.dmem_rvalid) begin
                    state_d               = ST_IDLE;
                    o_struct_d            = cap_q;
                    o_struct_d.rf_wr_data = al_ld;
                    o_stall               = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cap_q        <= '0;
            o_struct_q   <= '0;
            o_misalign_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            o_struct_q   <= o_struct_d;
            o_misalign_q <= o_misalign_d;
        end
    end

    // Port fields are only meaningful while a request is being offered.
    assign req             = (state_q == ST_REQ);
    assign bus.dmem_req    = req;
    assign bus.dmem_we     = req & cap_q.mem_wr;
    assign bus.dmem_addr   = req ? {cap_q.mem_addr[XLEN-1:3], 3'b000} : '0;
    assign bus.dmem_be     = req ? al_be : '0;
    assign bus.dmem_wdata  = req ? al_wdata : '0;

    assign o_struct   = o_struct_q;
    assign o_misalign = o_misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads with sign/zero extension, misalignment,
// reset during an access and back-to-back loads.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic                  clk;
    logic                  rst;
    interconnection_struct i_struct;
    interconnection_struct o_struct;
    logic                  o_stall;
    logic                  o_misalign;
    int                    n_checks;
    int                    n_errors;

    mem_lsu_if bus ();

    mem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .i_struct   (i_struct),
        .o_struct   (o_struct),
        .o_stall    (o_stall),
        .o_misalign (o_misalign),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic interconnection_struct mk(input logic rd, input logic wr, input logic [2:0] f3,
                                                 input logic [63:0] addr, input logic [63:0] data);
        interconnection_struct s;
        s          = '0;
        s.is_valid = 1'b1;
        s.rd       = 5'd7;
        s.rf_we    = rd;
        s.mem_rd   = rd;
        s.mem_wr   = wr;
        s.funct3   = f3;
        s.mem_addr = addr;
        s.mem_data = data;
        return s;
    endfunction

    initial begin
        interconnection_struct addi;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        i_struct = '0;
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata = '0;
        tick(); tick();
        check_eq("rst_req", bus.dmem_req, 1'b0);
        check_eq("rst_be", bus.dmem_be, 8'h00);
        check_eq("rst_addr", bus.dmem_addr, 64'h0);
        check_eq("rst_valid", o_struct.is_valid, 1'b0);
        check_eq("rst_misalign", o_misalign, 1'b0);
        rst = 1'b0;

        // SD, grant on the third request cycle
        tick();
        i_struct = mk(1'b0, 1'b1, F3_SD, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D);
        #1;
        check_eq("sd_accept_stall", o_stall, 1'b1);
        check_eq("sd_accept_req", bus.dmem_req, 1'b0);
        tick(); #1;
        check_eq("sd_req1", bus.dmem_req, 1'b1);
        check_eq("sd_we", bus.dmem_we, 1'b1);
        check_eq("sd_addr", bus.dmem_addr, 64'h1000);
        check_eq("sd_be", bus.dmem_be, 8'hFF);
        check_eq("sd_wdata", bus.dmem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check_eq("sd_stall1", o_stall, 1'b1);
        check_eq("sd_pending_valid", o_struct.is_valid, 1'b0);
        tick(); #1;
        check_eq("sd_req2", bus.dmem_req, 1'b1);
        check_eq("sd_stall2", o_stall, 1'b1);
        tick();
        bus.dmem_gnt = 1'b1;
        #1;
        check_eq("sd_req3", bus.dmem_req, 1'b1);
        check_eq("sd_wdata_hold", bus.dmem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check_eq("sd_gnt_stall", o_stall, 1'b0);
        tick();
        bus.dmem_gnt = 1'b0;
        i_struct = '0;
        #1;
        check_eq("sd_wb_valid", o_struct.is_valid, 1'b1);
        check_eq("sd_wb_addr", o_struct.mem_addr, 64'h1000);
        check_eq("sd_done_req", bus.dmem_req, 1'b0);
        check_eq("sd_done_stall", o_stall, 1'b0);
        tick(); #1;
        check_eq("sd_valid_once", o_struct.is_valid, 1'b0);

        // LB then LBU at 0x1003, grant and response together
        for (int k = 0; k < 2; k++) begin
            i_struct = mk(1'b1, 1'b0, (k == 0) ? F3_LB : F3_LBU, 64'h1003, 64'h0);
            #1;
            check_eq("lb_accept_stall", o_stall, 1'b1);
            tick();
            bus.dmem_gnt = 1'b1;
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata = 64'h0000_0000_8000_0000;
            #1;
            check_eq("lb_be", bus.dmem_be, 8'h08);
            check_eq("lb_addr", bus.dmem_addr, 64'h1000);
            check_eq("lb_we", bus.dmem_we, 1'b0);
            check_eq("lb_stall", o_stall, 1'b0);
            tick();
            bus.dmem_gnt = 1'b0;
            bus.dmem_rvalid = 1'b0;
            i_struct = '0;
            #1;
            check_eq("lb_valid", o_struct.is_valid, 1'b1);
            check_eq((k == 0) ? "lb_data" : "lbu_data", o_struct.rf_wr_data,
                     (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h0000_0000_0000_0080);
            tick();
        end

        // SH at 0x1006
        i_struct = mk(1'b0, 1'b1, F3_SH, 64'h1006, 64'h1234);
        tick();
        bus.dmem_gnt = 1'b1;
        #1;
        check_eq("sh_addr", bus.dmem_addr, 64'h1000);
        check_eq("sh_be", bus.dmem_be, 8'hC0);
        check_eq("sh_wdata", bus.dmem_wdata, 64'h1234_0000_0000_0000);
        tick();
        bus.dmem_gnt = 1'b0;
        i_struct = '0;
        #1;
        check_eq("sh_valid", o_struct.is_valid, 1'b1);
        tick();

        // Misaligned LW, then an ADDI flows through
        i_struct = mk(1'b1, 1'b0, F3_LW, 64'h1002, 64'h0);
        #1;
        check_eq("mis_stall", o_stall, 1'b0);
        tick();
        addi = '0;
        addi.is_valid = 1'b1;
        addi.rf_we = 1'b1;
        addi.rd = 5'd3;
        addi.rf_wr_data = 64'h55;
        i_struct = addi;
        #1;
        check_eq("mis_pulse", o_misalign, 1'b1);
        check_eq("mis_bubble", o_struct.is_valid, 1'b0);
        check_eq("mis_no_req", bus.dmem_req, 1'b0);
        check_eq("addi_no_stall", o_stall, 1'b0);
        tick();
        i_struct = '0;
        #1;
        check_eq("mis_pulse_end", o_misalign, 1'b0);
        check_eq("addi_valid", o_struct.is_valid, 1'b1);
        check_eq("addi_data", o_struct.rf_wr_data, 64'h55);
        tick();

        // LD with reset asserted while waiting for the response
        i_struct = mk(1'b1, 1'b0, F3_LD, 64'h3000, 64'h0);
        tick();
        bus.dmem_gnt = 1'b1;
        #1;
        check_eq("ld_gnt_stall", o_stall, 1'b1);
        tick();
        bus.dmem_gnt = 1'b0;
        #1;
        check_eq("ld_resp_req", bus.dmem_req, 1'b0);
        check_eq("ld_resp_stall", o_stall, 1'b1);
        rst = 1'b1;
        i_struct = '0;
        #1;
        check_eq("ldrst_stall", o_stall, 1'b0);
        check_eq("ldrst_req", bus.dmem_req, 1'b0);
        check_eq("ldrst_valid", o_struct.is_valid, 1'b0);
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 64'h1111_2222_3333_4444;
        #1;
        check_eq("late_rvalid_stall", o_stall, 1'b0);
        tick();
        bus.dmem_rvalid = 1'b0;
        #1;
        check_eq("late_rvalid_valid", o_struct.is_valid, 1'b0);
        check_eq("late_rvalid_req", bus.dmem_req, 1'b0);

        // Back-to-back LW then LWU
        i_struct = mk(1'b1, 1'b0, F3_LW, 64'h2000, 64'h0);
        tick();
        bus.dmem_gnt = 1'b1;
        #1;
        check_eq("lw_addr", bus.dmem_addr, 64'h2000);
        check_eq("lw_be", bus.dmem_be, 8'h0F);
        tick();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 64'hFFFF_FFFF_7FFF_FFFF;
        #1;
        check_eq("lw_resp_req", bus.dmem_req, 1'b0);
        check_eq("lw_resp_stall", o_stall, 1'b0);
        tick();
        bus.dmem_rvalid = 1'b0;
        i_struct = mk(1'b1, 1'b0, F3_LWU, 64'h2004, 64'h0);
        #1;
        check_eq("lw_valid", o_struct.is_valid, 1'b1);
        check_eq("lw_data", o_struct.rf_wr_data, 64'h0000_0000_7FFF_FFFF);
        check_eq("lwu_accept_stall", o_stall, 1'b1);
        tick();
        bus.dmem_gnt = 1'b1;
        bus.dmem_rvalid = 1'b1;
        #1;
        check_eq("lwu_be", bus.dmem_be, 8'hF0);
        check_eq("lwu_addr", bus.dmem_addr, 64'h2000);
        tick();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
        i_struct = '0;
        #1;
        check_eq("lwu_valid", o_struct.is_valid, 1'b1);
        check_eq("lwu_data", o_struct.rf_wr_data, 64'h0000_0000_FFFF_FFFF);
        tick();

        // Read and write flagged together behaves as a load
        i_struct = mk(1'b1, 1'b1, F3_SD, 64'h4000, 64'hAA);
        tick();
        #1;
        check_eq("rdwr_we", bus.dmem_we, 1'b0);
        bus.dmem_gnt = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
        i_struct = '0;
        #1;
        check_eq("rdwr_data", o_struct.rf_wr_data, 64'h0123_4567_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit. It consumes the interconnection_struct produced by the execute ALU: mem_addr, plus mem_data for stores.
- Drives a single-outstanding request/grant/response data-memory port.
- Aligns store data into byte lanes with byte enables; extracts and sign/zero-extends load data into rf_wr_data.
- Stalls the upstream pipeline while an access is in flight. Sits between EX and WB.

Parameters:
- XLEN, 64, datapath and address width.
- STRB_W, XLEN/8, byte-enable width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_struct  input  interconnection_struct  instruction from EX. Uses is_valid, mem_rd, mem_wr, mem_addr, mem_data, funct3.
- o_struct  output  interconnection_struct  registered instruction to WB
- o_stall  output  1  freeze upstream stages
- o_misalign  output  1  one-cycle pulse: misaligned access dropped
- dmem_req  output  1  request valid
- dmem_we  output  1  1=store, 0=load
- dmem_addr  output  XLEN  doubleword-aligned address (mem_addr with [2:0] cleared)
- dmem_be  output  STRB_W  byte enables
- dmem_wdata  output  XLEN  lane-aligned store data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  load response valid
- dmem_rdata  input  XLEN  load response data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
  - Reset values: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0; o_struct all-zero (is_valid=0); o_misalign=0.
- A memory op is i_struct.is_valid && (mem_rd || mem_wr). mem_rd and mem_wr together is illegal and is treated as a load.
- Non-memory instruction in IDLE: o_struct <= i_struct on the next edge (latency 1). o_stall=0.
- Alignment: size = funct3[1:0] (0 B, 1 H, 2 W, 3 D). Misaligned when addr[size-1:0] != 0.
  - Misaligned op: no request is issued.
  - o_misalign pulses 1 cycle.
  - o_struct <= i_struct with is_valid=0 (bubble).
  - No stall.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ on an aligned memory op. The op is captured into an internal register. o_stall=1 combinationally in that same cycle.
  - REQ: dmem_req=1, held with address/we/be/wdata stable until dmem_gnt.
    - Store with gnt -> IDLE. o_struct <= captured op.
    - Load with gnt and no rvalid -> RESP.
    - Load with gnt and rvalid in the same cycle -> IDLE with data.
  - RESP: dmem_req=0. On dmem_rvalid -> IDLE. o_struct <= captured op with rf_wr_data = extracted load.
  - o_stall=1 in REQ and RESP, and in the IDLE accept cycle. It deasserts in the cycle o_struct is loaded, so the next instruction is accepted one cycle later.
  - o_struct.is_valid=0 while an access is pending. The register holds its last value only for one cycle after writeback.
- Store lane formatting: off = addr[2:0].
  - dmem_be = ((1<<(1<<size))-1) << off.
  - dmem_wdata = mem_data << (8*off). Bytes outside the enables are don't-care and driven 0.
- Load extraction:
  - sh = dmem_rdata >> (8*off), truncated to 8/16/32/64 bits per size.
  - funct3[2]=0: sign-extend to XLEN. funct3[2]=1: zero-extend (LBU/LHU/LWU).
  - funct3=111 is illegal and is treated as LD.
- dmem_rvalid outside RESP (or outside the REQ+gnt cycle) is ignored.
- Reset mid-access:
  - FSM returns to IDLE immediately and dmem_req drops.
  - A late rvalid after reset is ignored.
  - The captured op is discarded.

Decomposition:
- Shared package: funct3 load/store encodings (LB..LWU, SB..SD), size constants, and the FSM state enum lsu_state_t.
- interconnection_struct fields mem_rd, mem_wr, mem_addr, mem_data and funct3 must exist in the shared struct package.
- One combinational sub-module, lsu_align: store lane/byte-enable generation and load extract/extend. The FSM, capture register and output register stay in mem_lsu.

Test Plan:
1. SD addr=0x1000, data=0xDEADBEEF_CAFEF00D, gnt after 2 cycles -> dmem_req held for 3 cycles, be=0xFF, wdata equals data, o_stall high 3 cycles, o_struct.is_valid for 1 cycle.
2. LB addr=0x1003, rdata=0x00000000_80000000 with gnt+rvalid same cycle -> rf_wr_data=0xFFFFFFFF_FFFFFF80, be=0x08. LBU at the same address -> 0x80.
3. SH addr=0x1006, mem_data=0x1234 -> dmem_addr=0x1000, be=0xC0, wdata=0x1234_0000_0000_0000.
4. LW addr=0x1002 (misaligned) -> no dmem_req, o_misalign pulse, o_struct.is_valid=0, no stall. Next ADDI passes through with 1-cycle latency.
5. LD issued, gnt, then rst asserted in RESP before rvalid -> all outputs zero immediately, state IDLE. Subsequent rvalid ignored and o_struct.is_valid stays 0.
6. Back-to-back LW 0x2000 (rdata[31:0]=0x7FFF_FFFF) then LWU 0x2004 (rdata[63:32]=0xFFFF_FFFF) -> rf_wr_data=0x7FFFFFFF, then 0x00000000_FFFFFFFF. Second op accepted only after first writeback.
